pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/pipe_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard inputs from decode/execute/memory and the
// stall, bubble and status outputs from the controller.
interface pipe_ctrl_if;
    logic [4:0]  decode_i_rs1;
    logic [4:0]  decode_i_rs2;
    logic        decode_i_rs1_used;
    logic        decode_i_rs2_used;
    logic        regE_i_is_load;
    logic [4:0]  regE_i_wb_rd;
    logic        execute_i_redirect;
    logic        regM_i_mem_req;
    logic        dmem_i_ack;
    logic        dmem_o_req;
    logic        ctrl_o_F_stall;
    logic        ctrl_o_D_stall;
    logic        ctrl_o_E_stall;
    logic        ctrl_o_M_stall;
    logic        ctrl_o_D_bubble;
    logic        ctrl_o_E_bubble;
    logic        ctrl_o_W_bubble;
    logic        ctrl_o_err;
    logic [31:0] ctrl_o_stall_cnt;
    logic [15:0] ctrl_o_flush_cnt;

    modport master (
        input  decode_i_rs1, decode_i_rs2, decode_i_rs1_used, decode_i_rs2_used,
        input  regE_i_is_load, regE_i_wb_rd, execute_i_redirect,
        input  regM_i_mem_req, dmem_i_ack,
        output dmem_o_req,
        output ctrl_o_F_stall, ctrl_o_D_stall, ctrl_o_E_stall, ctrl_o_M_stall,
        output ctrl_o_D_bubble, ctrl_o_E_bubble, ctrl_o_W_bubble,
        output ctrl_o_err, ctrl_o_stall_cnt, ctrl_o_flush_cnt
    );

    modport slave (
        output decode_i_rs1, decode_i_rs2, decode_i_rs1_used, decode_i_rs2_used,
        output regE_i_is_load, regE_i_wb_rd, execute_i_redirect,
        output regM_i_mem_req, dmem_i_ack,
        input  dmem_o_req,
        input  ctrl_o_F_stall, ctrl_o_D_stall, ctrl_o_E_stall, ctrl_o_M_stall,
        input  ctrl_o_D_bubble, ctrl_o_E_bubble, ctrl_o_W_bubble,
        input  ctrl_o_err, ctrl_o_stall_cnt, ctrl_o_flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait stalls with timeout,
// redirect flushes and load-use interlock, plus stall/flush statistics.
//
// state    | meaning
// S_RUN    | normal flow; zero-wait memory accesses pass without stall
// S_MEM_WAIT | data access outstanding, pipeline frozen, wait counter running
// S_ERR    | memory timeout; pipeline frozen and dmem request dropped until reset
module pipe_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    logic mem_stall;
    logic req_raw;
    logic load_use;
    logic redirect_apply;
    logic load_use_apply;
    logic f_stall, d_stall, e_stall, m_stall;
    logic d_bubble, e_bubble, w_bubble;
    logic dmem_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_RUN;
            wait_q      <= 8'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (f_stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect_apply && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_stall = 1'b0;
        req_raw   = 1'b0;
        case (state_q)
            S_RUN: begin
                req_raw = bus.regM_i_mem_req;
                wait_d  = 8'd0;
                if (bus.regM_i_mem_req && !bus.dmem_i_ack) begin
                    state_d   = S_MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                req_raw = bus.regM_i_mem_req;
                if (bus.dmem_i_ack) begin
                    state_d = S_RUN;
                    wait_d  = 8'd0;
                end else begin
                    mem_stall = 1'b1;
                    // an ack on the terminal cycle still completes normally
                    if (wait_q == MEM_TIMEOUT)
                        state_d = S_ERR;
                    else
                        wait_d = wait_q + 8'd1;
                end
            end
            S_ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                wait_d  = 8'd0;
            end
        endcase
    end

    always_comb begin
        load_use = bus.regE_i_is_load && (bus.regE_i_wb_rd != 5'd0) &&
                   (((bus.regE_i_wb_rd == bus.decode_i_rs1) && bus.decode_i_rs1_used) ||
                    ((bus.regE_i_wb_rd == bus.decode_i_rs2) && bus.decode_i_rs2_used));
        redirect_apply = rst && !mem_stall && bus.execute_i_redirect;
        load_use_apply = rst && !mem_stall && !bus.execute_i_redirect && load_use;

        f_stall  = 1'b0;
        d_stall  = 1'b0;
        e_stall  = 1'b0;
        m_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        w_bubble = 1'b0;
        dmem_req = 1'b0;
        if (rst) begin
            dmem_req = req_raw;
            if (mem_stall) begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_stall  = 1'b1;
                m_stall  = 1'b1;
                w_bubble = 1'b1;
            end else if (redirect_apply) begin
                d_bubble = 1'b1;
                e_bubble = 1'b1;
            end else if (load_use_apply) begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_bubble = 1'b1;
            end
        end
    end

    assign bus.dmem_o_req       = dmem_req;
    assign bus.ctrl_o_F_stall   = f_stall;
    assign bus.ctrl_o_D_stall   = d_stall;
    assign bus.ctrl_o_E_stall   = e_stall;
    assign bus.ctrl_o_M_stall   = m_stall;
    assign bus.ctrl_o_D_bubble  = d_bubble;
    assign bus.ctrl_o_E_bubble  = e_bubble;
    assign bus.ctrl_o_W_bubble  = w_bubble;
    assign bus.ctrl_o_err       = (state_q == S_ERR);
    assign bus.ctrl_o_stall_cnt = stall_cnt_q;
    assign bus.ctrl_o_flush_cnt = flush_cnt_q;

endmodule
